// File: rtl/l2h_word_packer.sv
// Byte-to-word packer with a small output FIFO and sticky overflow flag, clocked by rclk.
// Define L2H_FLUSH_EN to add an idle timer that pushes a partial word after FLUSH_CYCLES idle cycles.
//
// state  | meaning
// EMPTY  | no bytes held in the pack register (cnt = 0)
// FILL   | 0 < cnt < BPW bytes held, waiting for the rest of the word

module l2h_word_packer #(
   parameter int BPW          = 4,
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 64
) (
   input  logic                     rclk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [8*BPW-1:0]         out_data,
   output logic [$clog2(BPW):0]     out_bytes,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     ovf
);

   localparam int WW    = 8 * BPW;
   localparam int CNT_W = $clog2(BPW) + 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] LAST_LANE  = CNT_W'(BPW - 1);
   localparam logic [CNT_W-1:0] FULL_BYTES = CNT_W'(BPW);
   localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(DEPTH);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FILL  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WW-1:0]       pack_q, pack_d;
   logic [WW-1:0]       word_mem_q [DEPTH];
   logic [WW-1:0]       word_mem_d [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                ovf_q, ovf_d;

   logic [CNT_W-1:0]    lane_sel;
   logic                push_req;
   logic                push_ok;
   logic                pop;
   logic [WW-1:0]       push_word;

`ifdef L2H_FLUSH_EN
   localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYCLES - 1);

   logic [FL_W-1:0]     flush_q, flush_d;
   logic [CNT_W-1:0]    bytes_mem_q [DEPTH];
   logic [CNT_W-1:0]    bytes_mem_d [DEPTH];
   logic [CNT_W-1:0]    push_bytes;
`endif

   // ---------------------------------------------------------------- packer FSM
   always_ff @(posedge rclk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
         pack_q  <= '0;
`ifdef L2H_FLUSH_EN
         flush_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pack_q  <= pack_d;
`ifdef L2H_FLUSH_EN
         flush_q <= flush_d;
`endif
      end
   end

   // pack_q lanes at and above cnt are always zero, so a flushed word needs no masking
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pack_d    = pack_q;
      push_req  = 1'b0;
      push_word = pack_q;
      lane_sel  = (state_q == ST_EMPTY) ? '0 : cnt_q;
`ifdef L2H_FLUSH_EN
      flush_d    = '0;
      push_bytes = FULL_BYTES;
`endif
      if (in_valid) begin
         if (lane_sel == LAST_LANE) begin
            push_req              = 1'b1;
            push_word[WW-1 -: 8]  = in_data;
            cnt_d                 = '0;
            pack_d                = '0;
            state_d               = ST_EMPTY;
         end else begin
            for (int k = 0; k < BPW; k++) begin
               if (lane_sel == CNT_W'(k)) begin
                  pack_d[8*k +: 8] = in_data;
               end
            end
            cnt_d   = lane_sel + 1'b1;
            state_d = ST_FILL;
         end
      end
`ifdef L2H_FLUSH_EN
      else if (state_q == ST_FILL) begin
         if (flush_q == FL_LAST) begin
            push_req   = 1'b1;
            push_bytes = cnt_q;
            cnt_d      = '0;
            pack_d     = '0;
            state_d    = ST_EMPTY;
         end else begin
            flush_d = flush_q + 1'b1;
         end
      end
`endif
   end

   // ---------------------------------------------------------------- output FIFO
   assign out_valid  = (level_q != '0);
   assign pop        = out_valid && out_ready;
   assign push_ok    = push_req && ((level_q != FULL_LVL) || pop);
   assign fifo_level = level_q;
   assign ovf        = ovf_q;
   assign out_data   = out_valid ? word_mem_q[rd_ptr_q] : '0;

`ifdef L2H_FLUSH_EN
   assign out_bytes  = out_valid ? bytes_mem_q[rd_ptr_q] : '0;
`else
   assign out_bytes  = out_valid ? FULL_BYTES : '0;
`endif

   always_comb begin
      word_mem_d = word_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      ovf_d      = ovf_q | (push_req & ~push_ok);
`ifdef L2H_FLUSH_EN
      bytes_mem_d = bytes_mem_q;
`endif
      if (push_ok) begin
         word_mem_d[wr_ptr_q] = push_word;
`ifdef L2H_FLUSH_EN
         bytes_mem_d[wr_ptr_q] = push_bytes;
`endif
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // storage needs no reset: outputs are gated by out_valid
   always_ff @(posedge rclk) begin
      word_mem_q <= word_mem_d;
`ifdef L2H_FLUSH_EN
      bytes_mem_q <= bytes_mem_d;
`endif
   end

endmodule
